// File: rtl/video_timing_prog.sv
// Programmable video timing generator with double-buffered timing registers.
// Writes land in a shadow bank; the whole bank is copied to the active bank
// on the last pixel of a frame, so a frame is always drawn with one timing.
module video_timing_prog #(
    parameter int unsigned CW           = 10,
    parameter int unsigned H_ACTIVE     = 704,
    parameter int unsigned H_SYNC_START = 746,
    parameter int unsigned H_SYNC_END   = 854,
    parameter int unsigned H_TOTAL_M1   = 909,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned V_SYNC_END   = 492,
    parameter int unsigned V_TOTAL_M1   = 524,
    parameter bit          HSYNC_POL    = 1'b0,
    parameter bit          VSYNC_POL    = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_wr,
    input  logic [2:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wrdata,
    output logic          cfg_pending,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          blank,
    output logic          hlast,
    output logic          vlast,
    output logic          vnext,
    output logic          vnewframe
);

    // Register index map, shared by the shadow and active banks.
    localparam int unsigned R_H_ACTIVE = 0;
    localparam int unsigned R_HS_START = 1;
    localparam int unsigned R_HS_END   = 2;
    localparam int unsigned R_H_TOTAL  = 3;
    localparam int unsigned R_V_ACTIVE = 4;
    localparam int unsigned R_VS_START = 5;
    localparam int unsigned R_VS_END   = 6;
    localparam int unsigned R_V_TOTAL  = 7;

    localparam logic [CW-1:0] RST_VAL [8] = '{
        CW'(H_ACTIVE), CW'(H_SYNC_START), CW'(H_SYNC_END), CW'(H_TOTAL_M1),
        CW'(V_ACTIVE), CW'(V_SYNC_START), CW'(V_SYNC_END), CW'(V_TOTAL_M1)
    };

    logic [CW-1:0] hcnt_q, hcnt_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic [CW-1:0] act_q [8];
    logic [CW-1:0] act_d [8];
    logic [CW-1:0] shd_q [8];
    logic [CW-1:0] shd_d [8];
    logic          pending_q, pending_d;
    logic          vnewframe_q, vnewframe_d;
    logic          hs_on, vs_on, apply;

    // Zero-latency decode of counters against the active bank.
    always_comb begin
        hlast  = (hcnt_q == act_q[R_H_TOTAL]);
        vlast  = hlast && (vcnt_q == act_q[R_V_TOTAL]);
        hblank = (hcnt_q >= act_q[R_H_ACTIVE]);
        vblank = (vcnt_q >= act_q[R_V_ACTIVE]);
        blank  = hblank | vblank;
        vnext  = vcnt_q[0] & hlast;
        // Half-open windows; an empty or inverted window never fires.
        hs_on  = (act_q[R_HS_START] < act_q[R_HS_END]) &&
                 (hcnt_q >= act_q[R_HS_START]) && (hcnt_q < act_q[R_HS_END]);
        vs_on  = (act_q[R_VS_START] < act_q[R_VS_END]) &&
                 (vcnt_q >= act_q[R_VS_START]) && (vcnt_q < act_q[R_VS_END]);
        hsync  = HSYNC_POL ? hs_on : ~hs_on;
        vsync  = VSYNC_POL ? vs_on : ~vs_on;
        hpos        = hcnt_q;
        vpos        = vcnt_q;
        cfg_pending = pending_q;
        vnewframe   = vnewframe_q;
    end

    // Next-state: counters, shadow writes and the end-of-frame bank copy.
    always_comb begin
        hcnt_d      = hlast ? '0 : hcnt_q + 1'b1;
        vcnt_d      = vlast ? '0 : (hlast ? vcnt_q + 1'b1 : vcnt_q);
        vnewframe_d = hlast && (vcnt_q == act_q[R_V_ACTIVE]);
        apply       = vlast & pending_q;
        shd_d       = shd_q;
        act_d       = act_q;
        pending_d   = pending_q;
        // Active bank copies the shadow as it stood before any same-cycle write.
        if (apply) begin
            act_d     = shd_q;
            pending_d = 1'b0;
        end
        // A write in the apply cycle keeps pending set so it lands next frame.
        if (cfg_wr) begin
            shd_d[cfg_addr] = cfg_wrdata;
            pending_d       = 1'b1;
        end
    end

    // State registers; reset restores the parameter timing and drops pending writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            pending_q   <= 1'b0;
            vnewframe_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                act_q[i] <= RST_VAL[i];
                shd_q[i] <= RST_VAL[i];
            end
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            pending_q   <= pending_d;
            vnewframe_q <= vnewframe_d;
            for (int i = 0; i < 8; i++) begin
                act_q[i] <= act_d[i];
                shd_q[i] <= shd_d[i];
            end
        end
    end

endmodule

// File: tb/tb_video_timing_prog.sv
// Scoreboard bench: expected per-line / per-frame summaries are queued up
// front; monitors measure the DUT outputs and compare at each hlast / vlast.
module tb_video_timing_prog;

    localparam int CW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    // ---------------- default-parameter instance ----------------
    logic          rst_d = 1'b1;
    logic          d_wr = 1'b0;
    logic [2:0]    d_addr = '0;
    logic [CW-1:0] d_data = '0;
    logic          d_pend, d_hs, d_vs, d_hb, d_vb, d_bl, d_hl, d_vl, d_vn, d_nf;
    logic [CW-1:0] d_hpos, d_vpos;

    video_timing_prog u_d (
        .clk(clk), .reset(rst_d), .cfg_wr(d_wr), .cfg_addr(d_addr),
        .cfg_wrdata(d_data), .cfg_pending(d_pend), .hpos(d_hpos), .vpos(d_vpos),
        .hsync(d_hs), .vsync(d_vs), .hblank(d_hb), .vblank(d_vb), .blank(d_bl),
        .hlast(d_hl), .vlast(d_vl), .vnext(d_vn), .vnewframe(d_nf)
    );

    // ---------------- small-timing instance, hsync active high ----------------
    logic          rst_s = 1'b1;
    logic          s_wr = 1'b0;
    logic [2:0]    s_addr = '0;
    logic [CW-1:0] s_data = '0;
    logic          s_pend, s_hs, s_vs, s_hb, s_vb, s_bl, s_hl, s_vl, s_vn, s_nf;
    logic [CW-1:0] s_hpos, s_vpos;

    video_timing_prog #(
        .CW(CW), .H_ACTIVE(12), .H_SYNC_START(14), .H_SYNC_END(17), .H_TOTAL_M1(19),
        .V_ACTIVE(8), .V_SYNC_START(9), .V_SYNC_END(11), .V_TOTAL_M1(11),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_s (
        .clk(clk), .reset(rst_s), .cfg_wr(s_wr), .cfg_addr(s_addr),
        .cfg_wrdata(s_data), .cfg_pending(s_pend), .hpos(s_hpos), .vpos(s_vpos),
        .hsync(s_hs), .vsync(s_vs), .hblank(s_hb), .vblank(s_vb), .blank(s_bl),
        .hlast(s_hl), .vlast(s_vl), .vnext(s_vn), .vnewframe(s_nf)
    );

    // ---------------- scoreboard records ----------------
    typedef struct {
        int len; int hs; int hsf; int hbf; int vs0; int bl0; int vp; int vnx; int pend;
    } line_t;

    typedef struct {
        int len; int vis; int hs; int vs; int vnx; int nvf; int vfh; int vfv; int pend0; int pv;
    } frame_t;

    line_t  q_d [$];
    frame_t q_s [$];
    bit     mon_d_en = 1'b1;
    bit     mon_s_en = 1'b1;

    // Line monitor for the default instance (hsync active low).
    int l_len, l_hs, l_hsf, l_hbf, l_vs0, l_bl0, l_vp;
    always @(negedge clk) begin
        if (rst_d || !mon_d_en) begin
            l_len = 0; l_hs = 0; l_hsf = -1; l_hbf = -1; l_vs0 = -1; l_bl0 = -1; l_vp = -1;
        end else begin
            l_len++;
            if (d_hs == 1'b0) begin
                l_hs++;
                if (l_hsf < 0) l_hsf = int'(d_hpos);
            end
            if (d_hb && l_hbf < 0) l_hbf = int'(d_hpos);
            if (d_hpos == '0) begin
                l_vs0 = int'(d_vs); l_bl0 = int'(d_bl); l_vp = int'(d_vpos);
            end
            if (d_hl) begin
                if (q_d.size() == 0) begin
                    chk("line_sb_empty", 1, 0);
                end else begin
                    line_t e;
                    e = q_d.pop_front();
                    chk("line_len",    l_len,         e.len);
                    chk("line_hs_cnt", l_hs,          e.hs);
                    chk("line_hs_1st", l_hsf,         e.hsf);
                    chk("line_hb_1st", l_hbf,         e.hbf);
                    chk("line_vsync0", l_vs0,         e.vs0);
                    chk("line_blank0", l_bl0,         e.bl0);
                    chk("line_vpos",   l_vp,          e.vp);
                    chk("line_vnext",  int'(d_vn),    e.vnx);
                    chk("line_pend",   int'(d_pend),  e.pend);
                end
                l_len = 0; l_hs = 0; l_hsf = -1; l_hbf = -1; l_vs0 = -1; l_bl0 = -1; l_vp = -1;
            end
        end
    end

    // Frame monitor for the small instance (hsync active high, vsync active low).
    int f_len, f_vis, f_hs, f_vs, f_vnx, f_nvf, f_vfh, f_vfv, f_p0;
    always @(negedge clk) begin
        if (rst_s || !mon_s_en) begin
            f_len = 0; f_vis = 0; f_hs = 0; f_vs = 0; f_vnx = 0; f_nvf = 0;
            f_vfh = 0; f_vfv = 0; f_p0 = -1;
        end else begin
            f_len++;
            if (!s_bl) f_vis++;
            if (s_hs == 1'b1) f_hs++;
            if (s_vs == 1'b0) f_vs++;
            if (s_vn) f_vnx++;
            if (s_nf) begin
                f_nvf++; f_vfh = int'(s_hpos); f_vfv = int'(s_vpos);
            end
            if (s_hpos == '0 && s_vpos == '0) f_p0 = int'(s_pend);
            if (s_vl) begin
                if (q_s.size() == 0) begin
                    chk("frame_sb_empty", 1, 0);
                end else begin
                    frame_t e;
                    e = q_s.pop_front();
                    chk("frm_len",   f_len,        e.len);
                    chk("frm_vis",   f_vis,        e.vis);
                    chk("frm_hsync", f_hs,         e.hs);
                    chk("frm_vsync", f_vs,         e.vs);
                    chk("frm_vnext", f_vnx,        e.vnx);
                    chk("frm_nvf",   f_nvf,        e.nvf);
                    chk("frm_nf_h",  f_vfh,        e.vfh);
                    chk("frm_nf_v",  f_vfv,        e.vfv);
                    chk("frm_pend0", f_p0,         e.pend0);
                    chk("frm_pendv", int'(s_pend), e.pv);
                end
                f_len = 0; f_vis = 0; f_hs = 0; f_vs = 0; f_vnx = 0; f_nvf = 0;
                f_vfh = 0; f_vfv = 0; f_p0 = -1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr_s(input int a, input int d);
        s_wr = 1'b1; s_addr = 3'(a); s_data = CW'(d);
        @(negedge clk);
        s_wr = 1'b0;
    endtask

    task automatic wr_d(input int a, input int d);
        d_wr = 1'b1; d_addr = 3'(a); d_data = CW'(d);
        @(negedge clk);
        d_wr = 1'b0;
    endtask

    task automatic wait_s_line(input int v);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(s_vpos == CW'(v) && s_hpos == '0) && n < 1000);
        if (n >= 1000) chk("timeout_s_line", n, 0);
    endtask

    task automatic wait_s_vlast();
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!s_vl && n < 1000);
        if (n >= 1000) chk("timeout_s_vlast", n, 0);
    endtask

    task automatic wait_d_pos(input int v, input int h);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(d_vpos == CW'(v) && d_hpos == CW'(h)) && n < 5000);
        if (n >= 5000) chk("timeout_d_pos", n, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Default lines: 910 clocks, hsync low 746..853, hblank from 704.
        // A shadow write in line 2 raises pending but hblank stays at 704;
        // reset in line 4 discards it, leaving pending clear afterwards.
        q_d.push_back('{910, 108, 746, 704, 1, 0, 0, 0, 0});
        q_d.push_back('{910, 108, 746, 704, 1, 0, 1, 1, 0});
        q_d.push_back('{910, 108, 746, 704, 1, 0, 2, 0, 1});
        q_d.push_back('{910, 108, 746, 704, 1, 0, 3, 1, 1});
        q_d.push_back('{910, 108, 746, 704, 1, 0, 0, 0, 0});
        q_d.push_back('{910, 108, 746, 704, 1, 0, 1, 1, 0});

        //            len vis  hs  vs vnx nvf h  v  p0 pv
        q_s.push_back('{240, 96, 36, 40, 6, 1, 0, 9, 0, 1}); // reset timing 20x12
        q_s.push_back('{ 60, 24, 12, 10, 3, 1, 0, 5, 0, 1}); // small mode 10x6
        q_s.push_back('{ 60, 24, 12, 10, 3, 1, 0, 5, 1, 1}); // old H_TOTAL after collision
        q_s.push_back('{ 96, 24, 12, 16, 3, 1, 0, 5, 0, 1}); // 16-clock lines, H_ACTIVE write held
        q_s.push_back('{ 96, 40, 12, 16, 3, 1, 0, 5, 0, 1}); // H_ACTIVE = 10
        q_s.push_back('{ 96, 60,  0, 16, 3, 0, 0, 0, 0, 1}); // inverted hsync, V_ACTIVE > total
        q_s.push_back('{  6,  6,  0,  1, 3, 0, 0, 0, 0, 0}); // H_TOTAL_M1 = 0
        q_s.push_back('{  6,  6,  0,  1, 3, 0, 0, 0, 0, 0});

        repeat (3) @(posedge clk);
        #1;
        rst_d = 1'b0;
        rst_s = 1'b0;

        fork
            begin
                wait_d_pos(2, 10);
                wr_d(0, 100);
                wait_d_pos(4, 300);
                @(posedge clk);
                #1 rst_d = 1'b1;
                repeat (2) @(posedge clk);
                #1 rst_d = 1'b0;
                for (int n = 0; n < 3000 && q_d.size() != 0; n++) @(negedge clk);
                @(posedge clk);
                mon_d_en = 1'b0;
            end
            begin
                wait_s_line(2);
                wr_s(0, 6); wr_s(1, 7); wr_s(2, 9); wr_s(3, 9);
                wr_s(4, 4); wr_s(5, 4); wr_s(6, 5); wr_s(7, 5);
                wait_s_vlast();              // end of F0, small mode applied
                wait_s_line(2);
                wr_s(0, 6);                  // equal value still sets pending
                wait_s_vlast();              // end of F1: collide with apply
                wr_s(3, 15);
                wait_s_vlast();              // end of F2, H_TOTAL_M1 = 15 applied
                wait_s_line(2);
                wr_s(0, 10);
                wait_s_vlast();              // end of F3
                wait_s_line(2);
                wr_s(1, 9); wr_s(2, 7); wr_s(4, 7);
                wait_s_vlast();              // end of F4
                wait_s_line(2);
                wr_s(3, 0);
                wait_s_vlast();              // end of F5
                wait_s_vlast();              // end of F6
                wait_s_vlast();              // end of F7
                @(posedge clk);
                mon_s_en = 1'b0;
            end
        join

        chk("line_sb_drain",  q_d.size(), 0);
        chk("frame_sb_drain", q_s.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
